mul_div_unit: RTL
=================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand width; result width is 2*WIDTH.
REQ-002 The port clk SHALL be: input, 1 bit, the single clock, rising-edge active.
REQ-003 The port clr SHALL be: input, 1 bit, asynchronous, active-low reset (clr=0 resets).
REQ-004 The port start SHALL be: input, 1 bit, request; sampled only when busy=0.
REQ-005 The port op SHALL be: input, 1 bit; 0=signed multiply, 1=signed divide.
REQ-006 The ports a and b SHALL be: inputs, WIDTH bits; multiplicand/dividend and multiplier/divisor, two's complement.
REQ-007 The port busy SHALL be: output, 1 bit, operation in progress.
REQ-008 The port done SHALL be: output, 1 bit, single-cycle completion pulse.
REQ-009 The port result SHALL be: output, 2*WIDTH bits; MUL {hi,lo}=product, DIV {hi,lo}={remainder,quotient}; feeds HI/LO register load.
REQ-010 The port dz SHALL be: output, 1 bit, divide-by-zero flag for the last completed operation.

Function
REQ-011 The FSM SHALL have states IDLE, RUN, FIX, DONE; IDLE->RUN on start; RUN->FIX when iteration count expires; FIX->DONE; DONE->IDLE unconditionally.
REQ-012 On a start sampled at rising edge 0, the unit SHALL latch a, b and op at that same edge; later input changes SHALL have no effect.
REQ-013 Latency L SHALL be the number of edges from the start edge to the edge that asserts done: L=WIDTH+2 (34) for radix-2 MUL and for DIV.
REQ-014 done SHALL be high for exactly one cycle (the DONE state); result and dz SHALL update at the same edge and then hold until the next completion.
REQ-015 busy SHALL be high from the cycle after the start edge through the done cycle inclusive, and low in IDLE.
REQ-016 start while busy=1, including the done cycle, SHALL be ignored with no queueing.
REQ-017 MUL SHALL use Booth recoding and produce the exact 2*WIDTH-bit signed product.
REQ-018 DIV SHALL use restoring division on magnitudes, with FIX applying signs.
REQ-019 Quotient SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-020 DIV with 0x80000000 / -1 SHALL give quotient 0x80000000 and remainder 0, and SHALL NOT set dz.
REQ-021 DIV with b=0 SHALL skip RUN (IDLE->FIX->DONE, L=2) and give result {a, all-ones}, dz=1.
REQ-022 dz SHALL be 0 after any MUL or any nonzero-divisor DIV.
REQ-023 The iteration counter SHALL be log2(WIDTH)+1 bits and SHALL never wrap; it SHALL be reloaded on every IDLE->RUN transition.

Reset
REQ-024 When clr=0, the unit SHALL immediately force state IDLE, busy=0, done=0, dz=0, result=0, counter=0, and clear internal operand/accumulator registers.
REQ-025 clr asserted mid-operation SHALL abort the operation with no done pulse; after clr deasserts, the first start SHALL be accepted normally.
REQ-026 Reset deassertion SHALL be synchronised to clk before the FSM leaves IDLE.

Configuration
REQ-027 When the macro MULDIV_BOOTH_RADIX4_EN is defined, MUL SHALL use radix-4 Booth recoding (2 bits per iteration), giving MUL latency L=WIDTH/2+2 (18).
REQ-028 When MULDIV_BOOTH_RADIX4_EN is undefined, MUL SHALL use radix-2 Booth with L=34.
REQ-029 DIV behaviour and latency SHALL be identical with or without MULDIV_BOOTH_RADIX4_EN, and results SHALL be bit-identical in both builds.

Verification
REQ-030 MUL a=7, b=-3 (0xFFFFFFFD) -> result=0xFFFFFFFF_FFFFFFEB, dz=0, done at L=34 (18 with the macro).
REQ-031 MUL a=b=0x80000000 -> result=0x40000000_00000000; DIV a=-7, b=2 -> result=0xFFFFFFFF_FFFFFFFD (rem -1, quo -3), L=34.
REQ-032 DIV a=100, b=0 -> dz=1, result=0x00000064_FFFFFFFF, done at L=2; a subsequent MUL 2*3 -> result=6, dz=0.
REQ-033 DIV a=0x80000000, b=0xFFFFFFFF -> result=0x00000000_80000000, dz=0.
REQ-034 Start MUL 5*5, then pulse start with op=1 at edge 10 and at the done edge -> both pulses ignored, single done, result=25, busy low next cycle.
REQ-035 Start DIV, drive clr=0 at edge 15 -> busy=0, result=0 immediately, no done pulse; after release, MUL 4*4 -> result=16.

Source files
------------

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative signed multiply (Booth) / restoring divide unit
// Define MULDIV_BOOTH_RADIX4_EN for radix-4 Booth multiply; default build is radix-2.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic                 op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 dz
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int AW = WIDTH + 2;
`ifdef MULDIV_BOOTH_RADIX4_EN
  localparam logic [CW-1:0] MUL_ITERS = CW'(WIDTH / 2);
`else
  localparam logic [CW-1:0] MUL_ITERS = CW'(WIDTH);
`endif
  localparam logic [CW-1:0] DIV_ITERS = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state;
  logic [1:0]       rsync;
  logic [AW-1:0]    acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] mb;
  logic             q_1;
  logic             op_q;
  logic             dz_q;
  logic             neg_q;
  logic             neg_r;
  logic             fix_ph;
  logic [CW-1:0]    cnt;

  logic [AW-1:0]    mext, addend, sum, booth_acc, diff;
  logic [WIDTH-1:0] booth_mq, a_mag, b_mag;
  logic             booth_q1;
  logic [WIDTH:0]   rs;

  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  always_comb begin
    mext   = {{2{mb[WIDTH-1]}}, mb};
    addend = '0;
`ifdef MULDIV_BOOTH_RADIX4_EN
    case ({mq[1:0], q_1})
      3'b001, 3'b010: addend = mext;
      3'b011:         addend = mext << 1;
      3'b100:         addend = -(mext << 1);
      3'b101, 3'b110: addend = -mext;
      default:        addend = '0;
    endcase
    sum       = acc + addend;
    booth_acc = {{2{sum[AW-1]}}, sum[AW-1:2]};
    booth_mq  = {sum[1:0], mq[WIDTH-1:2]};
    booth_q1  = mq[1];
`else
    case ({mq[0], q_1})
      2'b01:   addend = mext;
      2'b10:   addend = -mext;
      default: addend = '0;
    endcase
    sum       = acc + addend;
    booth_acc = {sum[AW-1], sum[AW-1:1]};
    booth_mq  = {sum[0], mq[WIDTH-1:1]};
    booth_q1  = mq[0];
`endif
    // Restoring step: remainder shifted left with next dividend bit, trial-subtract divisor
    rs   = {acc[WIDTH-1:0], mq[WIDTH-1]};
    diff = {1'b0, rs} - {2'b00, mb};
  end

  // Deassertion of clr is synchronised; start is only honoured once rsync[1] is set
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) rsync <= '0;
    else      rsync <= {rsync[0], 1'b1};
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      dz     <= 1'b0;
      acc    <= '0;
      mq     <= '0;
      mb     <= '0;
      q_1    <= 1'b0;
      op_q   <= 1'b0;
      dz_q   <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      fix_ph <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && rsync[1]) begin
            busy   <= 1'b1;
            op_q   <= op;
            acc    <= '0;
            q_1    <= 1'b0;
            fix_ph <= 1'b0;
            if (op && (b == '0)) begin
              mq    <= a;
              mb    <= '0;
              dz_q  <= 1'b1;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= FIX;
            end else if (op) begin
              mq    <= a_mag;
              mb    <= b_mag;
              dz_q  <= 1'b0;
              neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
              neg_r <= a[WIDTH-1];
              cnt   <= DIV_ITERS;
              state <= RUN;
            end else begin
              mq    <= b;
              mb    <= a;
              dz_q  <= 1'b0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              cnt   <= MUL_ITERS;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (op_q) begin
            if (!diff[AW-1]) begin
              acc <= {1'b0, diff[WIDTH:0]};
              mq  <= {mq[WIDTH-2:0], 1'b1};
            end else begin
              acc <= {1'b0, rs};
              mq  <= {mq[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc <= booth_acc;
            mq  <= booth_mq;
            q_1 <= booth_q1;
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          // Two cycles: sign/dz fix-up in place, then publish result with done
          if (!fix_ph) begin
            fix_ph <= 1'b1;
            if (dz_q) begin
              acc <= {2'b00, mq};
              mq  <= '1;
            end else if (op_q) begin
              mq  <= neg_q ? -mq : mq;
              acc <= {2'b00, (neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0])};
            end
          end else begin
            result <= {acc[WIDTH-1:0], mq};
            dz     <= dz_q;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
